mld_7_4_enc_scheduler: RTL and testbench
========================================

# mld_7_4_enc_scheduler

Sequencer and two-requester arbiter for the serial (7,4) cyclic encoder used in the MLD datapath. It accepts 4-bit messages from two sources under valid/ready handshakes and grants the single encoder round-robin. It drives the encoder's `information_bit`/`sel` inputs through the 4 information, 3 parity and flush phases, deserialises the encoder's serial `out` into a 7-bit codeword, and presents that codeword with a source tag on a valid/ready output port.

## Interface

Parameters:
- `FLUSH_CYCLES`, 1: extra zero-shift cycles after parity; clears residual encoder state. Legal range 1..4.
- `MSB_FIRST`, 1: 1 sends `msg[3]` first; 0 sends `msg[0]` first.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset; shared with the encoder instance.
- `req0_valid` in 1: source 0 has a message.
- `req0_msg` in 4: source 0 message.
- `req0_ready` out 1: source 0 message accepted this cycle.
- `req1_valid` in 1: source 1 has a message.
- `req1_msg` in 4: source 1 message.
- `req1_ready` out 1: source 1 message accepted this cycle.
- `enc_info_bit` out 1: to encoder `information_bit`.
- `enc_sel` out 1: to encoder `sel`; 1 = information phase, 0 = parity/shift-out phase.
- `enc_out` in 1: from encoder `out`; sampled at the rising edge.
- `cw_valid` out 1: codeword register full.
- `cw_data` out 7: codeword; bit 6 is the first serial bit, bit 0 the last parity bit.
- `cw_src` out 1: source of `cw_data` (0 or 1).
- `cw_ready` in 1: consumer accepts the codeword.
- `busy` out 1: FSM not in IDLE.

## Operation

- FSM states: IDLE, INFO (4 cycles), PARITY (3 cycles), FLUSH (`FLUSH_CYCLES` cycles), then IDLE. A 3-bit phase counter drives every sequencing step.
- Grant condition: state IDLE, and (`cw_valid`==0 or `cw_ready`==1), and at least one `reqN_valid`.
- Arbitration:
  - `reqN_ready` is combinational and equals grant-to-N. At most one ready is high per cycle.
  - If only one source is valid, that source is granted.
  - If both are valid, the source not granted last is granted.
  - The `last_src` register resets to 1, so source 0 wins the first contention.
- On grant:
  - The message and source are latched.
  - `last_src` is updated.
  - The FSM moves to INFO.
- INFO:
  - `enc_sel`=1.
  - `enc_info_bit` = latched message bit in the order set by `MSB_FIRST`.
- PARITY and FLUSH: `enc_sel`=0, `enc_info_bit`=0.
- IDLE: `enc_sel`=0, `enc_info_bit`=0, so the encoder shifts zeros and stays cleared.
- Capture: in every INFO and PARITY cycle, `enc_out` is shifted into a 7-bit register, first bit ending in bit 6. FLUSH-cycle `enc_out` is ignored.
- On the edge that ends the last PARITY cycle:
  - The codeword is transferred to `cw_data`, and `cw_src` is set.
  - `cw_valid`=1.
  - Any old codeword was already consumed, as guaranteed by the grant condition.
- `cw_valid` clears on an edge where `cw_valid`&`cw_ready`, unless a new codeword loads on that same edge. Loading takes priority and holds `cw_valid`=1.
- The encoder cannot stall, so the FSM never pauses between grant and end of FLUSH. `cw_ready` has no effect on an in-flight word.
- `reqN_msg` may change after the grant cycle without effect.

## Timing

- Reset values (asynchronous, immediate):
  - state IDLE, `last_src`=1;
  - `enc_sel`=0, `enc_info_bit`=0;
  - `cw_valid`=0, `cw_data`=0, `cw_src`=0;
  - `busy`=0, `req0_ready`=`req1_ready`=0 while `reset` is high.
- Grant in cycle T:
  - INFO occupies T+1..T+4.
  - PARITY occupies T+5..T+7.
  - `cw_valid` is high from T+8.
  - FLUSH occupies T+8..T+7+`FLUSH_CYCLES`.
  - IDLE is reached at T+8+`FLUSH_CYCLES`, and the next grant is possible in that cycle.
- Throughput: 1 codeword per 8+`FLUSH_CYCLES` cycles, default 9.
- `busy`=1 from T+1 through the last FLUSH cycle.
- Output blocked: if `cw_valid`=1 and `cw_ready`=0 in IDLE, no grant is made and requests wait. Granting resumes in the cycle `cw_ready` rises.
- Reset mid-word: the in-flight word and any held codeword are discarded. No partial `cw_valid` is produced. After release the FSM is in IDLE and the first grant follows normal rules.

## Test plan

Bench encoder stub: `enc_out`=`enc_info_bit` when `enc_sel`=1; returns 1,0,1 in the three PARITY cycles.

- Single request: `req0_msg`=4'b1011 valid at T, `cw_ready`=1 -> `req0_ready` high at T only; `enc_sel`=1 T+1..T+4 with bits 1,0,1,1; `cw_data`=7'b1011101, `cw_src`=0, `cw_valid` at T+8; `busy` low at T+9.
- `MSB_FIRST`=0: msg 4'b1011 -> bits 1,1,0,1 -> `cw_data`=7'b1101101.
- Contention: both valid continuously after reset with msgs 4'h3 and 4'hC -> grants alternate 0,1,0,1 at 9-cycle spacing; `cw_src` sequence 0,1,0,1.
- Backpressure: `cw_ready`=0 for 20 cycles after the first codeword -> `cw_data` stable, no second grant, both `reqN_ready`=0; `cw_ready`=1 -> grant in that same cycle.
- Reset mid-word: assert `reset` at T+3 -> outputs go to reset values immediately; no `cw_valid`; after release, a pending `req1` is granted in the first cycle.
- `FLUSH_CYCLES`=4: back-to-back `req0` -> grants 12 cycles apart; `enc_sel`=0 and `enc_info_bit`=0 throughout FLUSH.

Source files
------------

// File: rtl/mld_7_4_enc_scheduler_if.sv
// Request, codeword and encoder-control signals of the (7,4) encoder scheduler.
// The scheduler takes the slave modport; the environment takes the master modport.
interface mld_7_4_enc_scheduler_if;
    logic       req0_valid;
    logic [3:0] req0_msg;
    logic       req0_ready;
    logic       req1_valid;
    logic [3:0] req1_msg;
    logic       req1_ready;
    logic       enc_info_bit;
    logic       enc_sel;
    logic       enc_out;
    logic       cw_valid;
    logic [6:0] cw_data;
    logic       cw_src;
    logic       cw_ready;
    logic       busy;

    modport master (
        output req0_valid, req0_msg, req1_valid, req1_msg, enc_out, cw_ready,
        input  req0_ready, req1_ready, enc_info_bit, enc_sel, cw_valid, cw_data, cw_src, busy
    );

    modport slave (
        input  req0_valid, req0_msg, req1_valid, req1_msg, enc_out, cw_ready,
        output req0_ready, req1_ready, enc_info_bit, enc_sel, cw_valid, cw_data, cw_src, busy
    );
endinterface

// File: rtl/mld_7_4_enc_scheduler.sv
// Round-robin arbiter and phase sequencer for a serial (7,4) cyclic encoder; collects the
// serial encoder output into a 7-bit codeword with a source tag.
module mld_7_4_enc_scheduler #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter bit          MSB_FIRST    = 1'b1
) (
    input logic                    clk,
    input logic                    reset,
    mld_7_4_enc_scheduler_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StInfo, StParity, StFlush} state_e;

    localparam logic [2:0] FlushLast = 3'(FLUSH_CYCLES - 1);

    state_e     state_q;
    logic [2:0] phase_q;
    logic [3:0] msg_q;
    logic       src_q;
    logic       last_src_q;
    logic [5:0] shift_q;
    logic       enc_sel_q;
    logic       enc_info_q;
    logic       cw_valid_q;
    logic [6:0] cw_data_q;
    logic       cw_src_q;

    logic       grant;
    logic       grant_src;
    logic [3:0] grant_msg;

    function automatic logic pick_bit(logic [3:0] m, logic [1:0] i);
        return MSB_FIRST ? m[2'd3 - i] : m[i];
    endfunction

    // Gated by reset so no ready is seen while the block is held in reset.
    always_comb begin
        grant     = !reset && (state_q == StIdle) && (!cw_valid_q || bus.cw_ready) &&
                    (bus.req0_valid || bus.req1_valid);
        grant_src = bus.req1_valid && (!bus.req0_valid || !last_src_q);
        grant_msg = grant_src ? bus.req1_msg : bus.req0_msg;
    end

    assign bus.req0_ready   = grant && !grant_src;
    assign bus.req1_ready   = grant && grant_src;
    assign bus.busy         = (state_q != StIdle);
    assign bus.enc_sel      = enc_sel_q;
    assign bus.enc_info_bit = enc_info_q;
    assign bus.cw_valid     = cw_valid_q;
    assign bus.cw_data      = cw_data_q;
    assign bus.cw_src       = cw_src_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            phase_q    <= 3'd0;
            msg_q      <= 4'd0;
            src_q      <= 1'b0;
            last_src_q <= 1'b1;
            shift_q    <= 6'd0;
            enc_sel_q  <= 1'b0;
            enc_info_q <= 1'b0;
            cw_valid_q <= 1'b0;
            cw_data_q  <= 7'd0;
            cw_src_q   <= 1'b0;
        end else begin
            // A codeword load in StParity below overrides this consume.
            if (cw_valid_q && bus.cw_ready) begin
                cw_valid_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        state_q    <= StInfo;
                        phase_q    <= 3'd0;
                        msg_q      <= grant_msg;
                        src_q      <= grant_src;
                        last_src_q <= grant_src;
                        enc_sel_q  <= 1'b1;
                        enc_info_q <= pick_bit(grant_msg, 2'd0);
                    end
                end
                StInfo: begin
                    shift_q <= {shift_q[4:0], bus.enc_out};
                    if (phase_q == 3'd3) begin
                        state_q    <= StParity;
                        phase_q    <= 3'd0;
                        enc_sel_q  <= 1'b0;
                        enc_info_q <= 1'b0;
                    end else begin
                        phase_q    <= phase_q + 3'd1;
                        enc_info_q <= pick_bit(msg_q, phase_q[1:0] + 2'd1);
                    end
                end
                StParity: begin
                    shift_q <= {shift_q[4:0], bus.enc_out};
                    if (phase_q == 3'd2) begin
                        state_q    <= StFlush;
                        phase_q    <= 3'd0;
                        cw_data_q  <= {shift_q, bus.enc_out};
                        cw_src_q   <= src_q;
                        cw_valid_q <= 1'b1;
                    end else begin
                        phase_q <= phase_q + 3'd1;
                    end
                end
                StFlush: begin
                    if (phase_q == FlushLast) begin
                        state_q <= StIdle;
                        phase_q <= 3'd0;
                    end else begin
                        phase_q <= phase_q + 3'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_mld_7_4_enc_scheduler.sv
// Two scheduler instances (default and LSB-first/4-flush) driven in lockstep and checked
// against a transaction-level timing model.
module tb_mld_7_4_enc_scheduler;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mld_7_4_enc_scheduler_if ifa ();
    mld_7_4_enc_scheduler_if ifb ();

    mld_7_4_enc_scheduler #(.FLUSH_CYCLES(1), .MSB_FIRST(1'b1)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    mld_7_4_enc_scheduler #(.FLUSH_CYCLES(4), .MSB_FIRST(1'b0)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    assign ifb.req0_valid = ifa.req0_valid;
    assign ifb.req0_msg   = ifa.req0_msg;
    assign ifb.req1_valid = ifa.req1_valid;
    assign ifb.req1_msg   = ifa.req1_msg;
    assign ifb.cw_ready   = ifa.cw_ready;

    // Encoder stubs: echo the info bit, then return 1,0,1 in the three cycles after info.
    logic [2:0] pc_a = 3'd7;
    logic [2:0] pc_b = 3'd7;
    always @(posedge clk) begin
        pc_a <= ifa.enc_sel ? 3'd0 : ((pc_a == 3'd7) ? 3'd7 : pc_a + 3'd1);
        pc_b <= ifb.enc_sel ? 3'd0 : ((pc_b == 3'd7) ? 3'd7 : pc_b + 3'd1);
    end
    assign ifa.enc_out = ifa.enc_sel ? ifa.enc_info_bit : (pc_a == 3'd0 || pc_a == 3'd2);
    assign ifb.enc_out = ifb.enc_sel ? ifb.enc_info_bit : (pc_b == 3'd0 || pc_b == 3'd2);

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         flush_n[2] = '{1, 4};
    bit         msb[2]     = '{1'b1, 1'b0};
    int         idle_at[2];
    int         g_t[2];
    int         load_at[2];
    logic [3:0] g_msg[2];
    logic       m_valid[2];
    logic [6:0] m_data[2];
    logic       m_src[2];
    logic [6:0] ld_cw[2];
    logic       ld_src[2];
    logic       last[2];

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s dut%0d cycle %0d observed %0h expected %0h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic model_reset(int k);
        m_valid[k] = 1'b0;
        m_data[k]  = 7'd0;
        m_src[k]   = 1'b0;
        last[k]    = 1'b1;
        g_t[k]     = -100;
        idle_at[k] = 0;
        load_at[k] = -1;
    endtask

    task automatic model_step(int k);
        logic r0, r1, sel, ib, cv, cs, bz, grant, pick, e_sel, e_ib;
        logic [6:0] cd, cw;
        logic [3:0] m;
        int i;
        r0  = (k == 0) ? ifa.req0_ready   : ifb.req0_ready;
        r1  = (k == 0) ? ifa.req1_ready   : ifb.req1_ready;
        sel = (k == 0) ? ifa.enc_sel      : ifb.enc_sel;
        ib  = (k == 0) ? ifa.enc_info_bit : ifb.enc_info_bit;
        cv  = (k == 0) ? ifa.cw_valid     : ifb.cw_valid;
        cd  = (k == 0) ? ifa.cw_data      : ifb.cw_data;
        cs  = (k == 0) ? ifa.cw_src       : ifb.cw_src;
        bz  = (k == 0) ? ifa.busy         : ifb.busy;
        if (reset) begin
            model_reset(k);
            chk("rst_ready0", k, r0, 0);
            chk("rst_ready1", k, r1, 0);
            chk("rst_sel", k, sel, 0);
            chk("rst_info", k, ib, 0);
            chk("rst_cw_valid", k, cv, 0);
            chk("rst_cw_data", k, cd, 0);
            chk("rst_cw_src", k, cs, 0);
            chk("rst_busy", k, bz, 0);
            return;
        end
        grant = (cyc >= idle_at[k]) && (!m_valid[k] || ifa.cw_ready) &&
                (ifa.req0_valid || ifa.req1_valid);
        pick  = ifa.req1_valid && (!ifa.req0_valid || !last[k]);
        e_sel = (cyc >= g_t[k] + 1) && (cyc <= g_t[k] + 4);
        i     = cyc - g_t[k] - 1;
        e_ib  = 1'b0;
        if (e_sel) e_ib = msb[k] ? g_msg[k][3 - i] : g_msg[k][i];
        chk("req0_ready", k, r0, grant && !pick);
        chk("req1_ready", k, r1, grant && pick);
        chk("enc_sel", k, sel, e_sel);
        chk("enc_info_bit", k, ib, e_ib);
        chk("busy", k, bz, (cyc > g_t[k]) && (cyc < idle_at[k]));
        chk("cw_valid", k, cv, m_valid[k]);
        chk("cw_data", k, cd, m_data[k]);
        chk("cw_src", k, cs, m_src[k]);
        if (grant) begin
            m          = pick ? ifa.req1_msg : ifa.req0_msg;
            last[k]    = pick;
            g_t[k]     = cyc;
            g_msg[k]   = m;
            idle_at[k] = cyc + 8 + flush_n[k];
            load_at[k] = cyc + 8;
            cw         = 7'b0000101;
            for (int j = 0; j < 4; j++) cw[6 - j] = msb[k] ? m[3 - j] : m[j];
            ld_cw[k]   = cw;
            ld_src[k]  = pick;
        end
        if (load_at[k] == cyc + 1) begin
            m_valid[k] = 1'b1;
            m_data[k]  = ld_cw[k];
            m_src[k]   = ld_src[k];
            load_at[k] = -1;
        end else if (m_valid[k] && ifa.cw_ready) begin
            m_valid[k] = 1'b0;
        end
    endtask

    task automatic cycle();
        #1;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(logic v0, logic [3:0] m0, logic v1, logic [3:0] m1, logic rdy);
        ifa.req0_valid = v0;
        ifa.req0_msg   = m0;
        ifa.req1_valid = v1;
        ifa.req1_msg   = m1;
        ifa.cw_ready   = rdy;
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        drive(1'b1, 4'hA, 1'b1, 4'h5, 1'b1);
        @(posedge clk);
        #1;
        repeat (2) cycle();
        reset = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        repeat (2) cycle();

        // Single request from source 0, then hold the codeword with backpressure.
        drive(1'b1, 4'b1011, 1'b0, 4'h0, 1'b1);
        cycle();
        drive(1'b0, 4'h6, 1'b0, 4'h9, 1'b0);
        repeat (13) cycle();
        #1;
        chk("ex_cw_a", 0, ifa.cw_data, 7'b1011101);
        chk("ex_cw_b", 1, ifb.cw_data, 7'b1101101);
        chk("ex_src_a", 0, ifa.cw_src, 0);
        chk("ex_valid_b", 1, ifb.cw_valid, 1);

        // Continuous contention, free-running consumer.
        drive(1'b1, 4'h3, 1'b1, 4'hC, 1'b1);
        repeat (40) cycle();

        // Backpressure with both sources waiting, then release.
        ifa.cw_ready = 1'b0;
        repeat (25) cycle();
        ifa.cw_ready = 1'b1;
        repeat (5) cycle();

        // Reset three cycles into a word while source 1 is pending.
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        repeat (14) cycle();
        drive(1'b1, 4'hE, 1'b0, 4'h0, 1'b1);
        cycle();
        drive(1'b0, 4'h0, 1'b1, 4'h7, 1'b1);
        repeat (2) cycle();
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        repeat (15) cycle();

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(3, 0) == 0) ifa.req0_valid = ~ifa.req0_valid;
            if ($urandom_range(3, 0) == 0) ifa.req1_valid = ~ifa.req1_valid;
            if ($urandom_range(1, 0) == 0) ifa.req0_msg = 4'($urandom);
            if ($urandom_range(1, 0) == 0) ifa.req1_msg = 4'($urandom);
            ifa.cw_ready = ($urandom_range(3, 0) != 0);
            reset = ($urandom_range(149, 0) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
